// File: rtl/cic_interpolator.sv
// ---------------------------------------------------------------------------
// cic_interpolator
//
// N-stage CIC interpolator. Low-rate signed 32-bit samples are taken once
// every 2^tc_a ticks, run through N comb stages at the low rate, zero-stuffed
// up to the tick rate and integrated by N integrators at the tick rate. The
// last integrator is normalised by an arithmetic shift of tc_a*(N-1) so DC
// passes with unity gain, then saturated to 32 bits.
//
// Ports
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset, clears all state
//   tick       high-rate step enable (one output sample per tick)
//   TC         log2 of the rate change; takes effect at the next phase wrap
//   IN         signed low-rate input, sampled on phase-0 ticks
//   IN_ACK     one-CLK pulse after each sampling tick
//   OUT        signed high-rate output, holds between ticks
//   OUT_VALID  one-CLK pulse after each tick (when OUT updates)
// ---------------------------------------------------------------------------
module cic_interpolator #(
  parameter int N = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        tick,
  input  logic [3:0]  TC,
  input  logic [31:0] IN,
  output logic        IN_ACK,
  output logic [31:0] OUT,
  output logic        OUT_VALID
);

  // Integrator growth is at most R^(N-1) on a 32-bit input, so 16 guard bits
  // per stage keep the final integrator's true value representable.
  localparam int ACC_W = 32 + 16 * N;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

  // Floor division by 2^sh.
  function automatic logic signed [ACC_W-1:0] shr_floor(
    input logic signed [ACC_W-1:0] v,
    input logic [7:0]              sh
  );
    return v >>> sh;
  endfunction

  // Clamp to the signed 32-bit range.
  function automatic logic [31:0] sat32(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      return 32'h7fff_ffff;
    end else if (v < SAT_MIN) begin
      return 32'h8000_0000;
    end else begin
      return v[31:0];
    end
  endfunction

  // Control state
  logic [14:0] ph;
  logic [3:0]  tc_a;
  logic [14:0] ph_last;
  logic        samp;
  logic [7:0]  sh;

  // Datapath state: comb/delay at the low rate, integrators at the tick rate
  logic signed [ACC_W-1:0] comb_p0  [N];
  logic signed [ACC_W-1:0] dly_p0   [N];
  logic signed [ACC_W-1:0] integ_p1 [N];

  logic signed [ACC_W-1:0] comb_in  [N];
  logic signed [ACC_W-1:0] integ_in [N];
  logic signed [ACC_W-1:0] acc_next;

  assign ph_last = 15'((32'd1 << tc_a) - 32'd1);
  assign samp    = (ph == 15'd0);
  assign sh      = 8'(tc_a) * 8'(N - 1);

  always_comb begin
    // Comb stage inputs: c0 is the sign-extended sample, then each stage
    // feeds the next from its registered value.
    comb_in[0] = {{(ACC_W-32){IN[31]}}, IN};
    for (int i = 1; i < N; i++) begin
      comb_in[i] = comb_p0[i-1];
    end
    // Zero-stuffing: the comb output only enters on phase-0 ticks.
    integ_in[0] = samp ? comb_p0[N-1] : '0;
    for (int j = 1; j < N; j++) begin
      integ_in[j] = integ_p1[j-1];
    end
    // Value the last integrator takes at this tick; OUT is loaded from it so
    // OUT and OUT_VALID change on the same edge.
    acc_next = integ_p1[N-1] + integ_in[N-1];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ph        <= '0;
      tc_a      <= '0;
      IN_ACK    <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT       <= '0;
      for (int i = 0; i < N; i++) begin
        comb_p0[i]  <= '0;
        dly_p0[i]   <= '0;
        integ_p1[i] <= '0;
      end
    end else begin
      IN_ACK    <= tick && samp;
      OUT_VALID <= tick;
      if (tick) begin
        // Stage p0: comb section, low rate
        if (samp) begin
          for (int i = 0; i < N; i++) begin
            comb_p0[i] <= comb_in[i] - dly_p0[i];
            dly_p0[i]  <= comb_in[i];
          end
        end
        // Stage p1: integrator section, tick rate (wraps modulo 2^ACC_W)
        for (int j = 0; j < N; j++) begin
          integ_p1[j] <= integ_p1[j] + integ_in[j];
        end
        // Stage p2: gain normalisation with the rate in force at this tick
        OUT <= sat32(shr_floor(acc_next, sh));
        // A new rate is adopted only at a phase wrap (R=1 wraps every tick).
        if (ph == ph_last) begin
          ph   <= '0;
          tc_a <= TC;
        end else begin
          ph <= ph + 15'd1;
        end
      end
    end
  end

endmodule

// File: doc/cic_interpolator.md
# cic_interpolator

Multi-stage CIC interpolator: the rate-raising counterpart of the lock-in's CIC decimator, used to upsample low-rate signed 32-bit samples (e.g. reference/output synthesis paths toward the DAC) to the `tick` rate. Takes one input sample every 2^TC ticks and produces one output sample per tick. Gain is normalised by a power-of-two shift so that DC passes with unity gain.

## Interface
- `N`, 3: number of comb and integrator stages (1..6).
- `ACC_W`, 32+16*N: internal two's-complement width, derived and not for override.
- `CLK`  in  1: system clock; all logic is on the rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `tick`  in  1: output-rate enable; every CLK with `tick`=1 is one high-rate step; back-to-back ticks are allowed.
- `TC`  in  4: log2 of the rate change R (R = 2^TC, 1..32768).
- `IN`  in  32: signed low-rate input sample.
- `IN_ACK`  out  1: one-CLK pulse in the cycle after `IN` was sampled; upstream presents the next sample.
- `OUT`  out  32: signed high-rate output.
- `OUT_VALID`  out  1: one-CLK pulse when `OUT` updates.

## Operation
- Phase counter `ph` and active rate `tc_a`. On a tick, `IN` is sampled iff `ph`==0. `ph` advances to `ph+1`, or wraps to 0 when `ph`==2^`tc_a`-1. When `ph` wraps, or stays 0 because R=1, `tc_a` <= `TC`.
- `TC` changes take effect only at a phase wrap. Integrators are not cleared, so a gain/rate transient is accepted.
- Comb section: N registered stages advance only on phase-0 ticks.
  - Stage input: c0 = sign-extended `IN`.
  - Stage update: c_i <= c_(i-1) - d_i, then d_i <= c_(i-1), using the old register values.
- Zero-stuffing: u0 = c_N on phase-0 ticks, else 0.
- Integrator section: N registered stages advance on every tick; a_j <= a_j + u_(j-1), with u_j = a_j (register value).
- Integrators wrap modulo 2^ACC_W by design.
- Output stage: the last integrator is arithmetically shifted right (floor) by `tc_a`*(N-1), saturated to [-2^31, 2^31-1], and registered into `OUT` on the CLK after the tick.
  - The shift uses the `tc_a` in force at that tick.
- No back-pressure. If upstream has not updated `IN` by the next phase-0 tick, the stale value is sampled.

## Timing
- Reset values:
  - `ph`, `tc_a`, all comb/delay/integrator registers: 0.
  - `OUT`=0, `OUT_VALID`=0, `IN_ACK`=0.
- Reset asserted mid-stream clears all state immediately. The first tick after release samples `IN`, since `ph`=0 and R=1 until `TC` is latched.
- `IN_ACK`: registered, high exactly one CLK after each sampling tick.
- `OUT_VALID`: registered, high exactly one CLK after each tick; `OUT` holds between ticks.
- Latency: the first output influenced by a sample appears at tick index 2^TC*N + N - 1, counting the sampling tick as 0. `OUT` changes one CLK later.
  - N=3, TC=0: 5 ticks. N=3, TC=1: 8 ticks.
- With `tick` held low, nothing changes except that `IN_ACK`/`OUT_VALID` drop.
- TC=0: the design is a pure 2N-1-tick delay, OUT = IN.
- Steady state:
  - Constant input X gives OUT = X exactly.
  - The step response is monotonic with no overshoot, because every polyphase sums to R^(N-1).

## Test plan
- Reset then TC=0, N=3, `tick` every CLK, IN ramps 100,101,102… -> OUT reproduces IN delayed 5 ticks. `IN_ACK` and `OUT_VALID` pulse each cycle, one CLK after the tick.
- TC=1, N=3, impulse IN=4 on one sampling tick, 0 otherwise -> OUT = 1,3,3,1 after ticks 8..11, 0 elsewhere. IN=-4 gives -1,-3,-3,-1.
- TC=5, constant IN=-123456, `tick` one CLK in ten -> OUT rises monotonically to exactly -123456 and holds.
  - `IN_ACK` once per 32 ticks.
  - `OUT_VALID` one CLK after each tick, never during the gaps.
- IN=0x7FFFFFFF, then 0x80000000 held, TC=4 -> OUT settles to each extreme exactly, with no wrap or overshoot. A forced TC change 4→0 mid-stream latches only at the phase wrap, and any transient excursion is clamped to the 32-bit limits.
- Change TC 2→3 at `ph`=1 -> R stays 4 until the wrap, then `IN_ACK` spacing becomes 8 ticks. Constant input resettles to the input value.
- Assert RST for 1 CLK mid-stream (TC=3) -> all outputs are 0 immediately. The first tick after release samples `IN` and `IN_ACK` pulses.
